// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: consumer of the decode control word.
// Carries control through the E, M and W stage registers. Resolves jumps and
// branches in E, detects load-use hazards and selects ALU forwarding sources.
// Ports:
//   i_clk, i_rst                     clock, async active-high reset
//   i_*_d                            D-stage control word and register addresses
//   i_zero_e, i_neg_e                ALU flags of the E-stage instruction
//   o_ex_e, o_pc_src_e               E-stage ALU op, next-PC select
//   o_fwd_a_e, o_fwd_b_e             operand forwarding selects
//   o_stall_fd, o_flush_fd           IF/ID hold / clear
//   o_*_m, o_rd_m                    M-stage control
//   o_reg_we_w, o_memory_read_w, o_rd_w  W-stage control
module ctrl_pipe_hazard #(
    parameter int unsigned RA_W = 5,
    parameter int unsigned EX_W = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_memory_we_d,
    input  logic            i_reg_we_d,
    input  logic            i_memory_read_d,
    input  logic            i_slt_d,
    input  logic            i_lui_d,
    input  logic [EX_W-1:0] i_ex_d,
    input  logic [1:0]      i_jump_t_d,
    input  logic [1:0]      i_branch_t_d,
    input  logic [RA_W-1:0] i_rd_d,
    input  logic [RA_W-1:0] i_rs1_d,
    input  logic [RA_W-1:0] i_rs2_d,
    input  logic            i_zero_e,
    input  logic            i_neg_e,
    output logic [EX_W-1:0] o_ex_e,
    output logic [1:0]      o_pc_src_e,
    output logic [1:0]      o_fwd_a_e,
    output logic [1:0]      o_fwd_b_e,
    output logic            o_stall_fd,
    output logic            o_flush_fd,
    output logic            o_memory_we_m,
    output logic            o_memory_read_m,
    output logic            o_reg_we_m,
    output logic            o_slt_m,
    output logic            o_lui_m,
    output logic [RA_W-1:0] o_rd_m,
    output logic            o_reg_we_w,
    output logic            o_memory_read_w,
    output logic [RA_W-1:0] o_rd_w
);

    localparam logic [1:0] JT_JAL    = 2'b01;
    localparam logic [1:0] JT_JALR   = 2'b10;
    localparam logic [1:0] JT_BRANCH = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    // E-stage registers
    logic            r_memory_we_e, r_reg_we_e, r_memory_read_e, r_slt_e, r_lui_e;
    logic [EX_W-1:0] r_ex_e;
    logic [1:0]      r_jump_t_e, r_branch_t_e;
    logic [RA_W-1:0] r_rd_e, r_rs1_e, r_rs2_e;

    // M-stage registers
    logic            r_memory_we_m, r_memory_read_m, r_reg_we_m, r_slt_m, r_lui_m;
    logic [RA_W-1:0] r_rd_m;

    // W-stage registers
    logic            r_reg_we_w, r_memory_read_w;
    logic [RA_W-1:0] r_rd_w;

    logic       w_load_use;
    logic       w_cond;
    logic       w_taken;
    logic       w_bubble_e;
    logic [1:0] w_pc_src;

    // Load-use: the load's data is not available to the instruction right behind it.
    assign w_load_use = r_memory_read_e && (r_rd_e != '0) &&
                        ((r_rd_e == i_rs1_d) || (r_rd_e == i_rs2_d));

    // Branch condition and next-PC selection
    always_comb begin
        w_cond   = 1'b0;
        w_taken  = 1'b0;
        w_pc_src = 2'b00;
        case (r_branch_t_e)
            2'b00:   w_cond = i_zero_e;
            2'b01:   w_cond = !i_zero_e;
            2'b10:   w_cond = i_neg_e;
            default: w_cond = !i_neg_e;
        endcase
        w_taken = (r_jump_t_e == JT_JAL) || (r_jump_t_e == JT_JALR) ||
                  ((r_jump_t_e == JT_BRANCH) && w_cond);
        if (r_jump_t_e == JT_JALR) begin
            w_pc_src = 2'b10;
        end else if (w_taken) begin
            w_pc_src = 2'b01;
        end
    end

    assign w_bubble_e = w_load_use || w_taken;

    // M result has priority over W; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
        logic [1:0] sel;
        sel = FWD_REG;
        if (r_reg_we_m && (r_rd_m != '0) && (r_rd_m == src)) begin
            sel = FWD_M;
        end else if (r_reg_we_w && (r_rd_w != '0) && (r_rd_w == src)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    // D -> E, replaced by an all-zero bubble on a hazard or redirect
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_memory_we_e   <= 1'b0;
            r_reg_we_e      <= 1'b0;
            r_memory_read_e <= 1'b0;
            r_slt_e         <= 1'b0;
            r_lui_e         <= 1'b0;
            r_ex_e          <= '0;
            r_jump_t_e      <= 2'b00;
            r_branch_t_e    <= 2'b00;
            r_rd_e          <= '0;
            r_rs1_e         <= '0;
            r_rs2_e         <= '0;
        end else if (w_bubble_e) begin
            r_memory_we_e   <= 1'b0;
            r_reg_we_e      <= 1'b0;
            r_memory_read_e <= 1'b0;
            r_slt_e         <= 1'b0;
            r_lui_e         <= 1'b0;
            r_ex_e          <= '0;
            r_jump_t_e      <= 2'b00;
            r_branch_t_e    <= 2'b00;
            r_rd_e          <= '0;
            r_rs1_e         <= '0;
            r_rs2_e         <= '0;
        end else begin
            r_memory_we_e   <= i_memory_we_d;
            r_reg_we_e      <= i_reg_we_d;
            r_memory_read_e <= i_memory_read_d;
            r_slt_e         <= i_slt_d;
            r_lui_e         <= i_lui_d;
            r_ex_e          <= i_ex_d;
            r_jump_t_e      <= i_jump_t_d;
            r_branch_t_e    <= i_branch_t_d;
            r_rd_e          <= i_rd_d;
            r_rs1_e         <= i_rs1_d;
            r_rs2_e         <= i_rs2_d;
        end
    end

    // E -> M -> W, free-running
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_memory_we_m   <= 1'b0;
            r_memory_read_m <= 1'b0;
            r_reg_we_m      <= 1'b0;
            r_slt_m         <= 1'b0;
            r_lui_m         <= 1'b0;
            r_rd_m          <= '0;
            r_reg_we_w      <= 1'b0;
            r_memory_read_w <= 1'b0;
            r_rd_w          <= '0;
        end else begin
            r_memory_we_m   <= r_memory_we_e;
            r_memory_read_m <= r_memory_read_e;
            r_reg_we_m      <= r_reg_we_e;
            r_slt_m         <= r_slt_e;
            r_lui_m         <= r_lui_e;
            r_rd_m          <= r_rd_e;
            r_reg_we_w      <= r_reg_we_m;
            r_memory_read_w <= r_memory_read_m;
            r_rd_w          <= r_rd_m;
        end
    end

    assign o_ex_e          = r_ex_e;
    assign o_pc_src_e      = w_pc_src;
    assign o_fwd_a_e       = fwd_sel(r_rs1_e);
    assign o_fwd_b_e       = fwd_sel(r_rs2_e);
    assign o_flush_fd      = w_taken;
    assign o_stall_fd      = w_load_use && !w_taken;
    assign o_memory_we_m   = r_memory_we_m;
    assign o_memory_read_m = r_memory_read_m;
    assign o_reg_we_m      = r_reg_we_m;
    assign o_slt_m         = r_slt_m;
    assign o_lui_m         = r_lui_m;
    assign o_rd_m          = r_rd_m;
    assign o_reg_we_w      = r_reg_we_w;
    assign o_memory_read_w = r_memory_read_w;
    assign o_rd_w          = r_rd_w;

endmodule
